// File: rtl/cia_pkg.sv
// Shared CIA types and constants.
//   reg4_t / reg8_t : register address and data bus types
//   icr_t           : ICR read layout {ir, unused[1:0], flag, sp, tod, tb, ta}
//   ICR_ADDR        : register number of the interrupt control register
//   ICR_TA..ICR_FLG : bit positions of the individual interrupt sources
package cia;

  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic       ir;
    logic [1:0] unused;
    logic       flg;
    logic       sp;
    logic       tod;
    logic       tb;
    logic       ta;
  } icr_t;

  localparam reg4_t ICR_ADDR = 4'hD;

  localparam int ICR_TA  = 0;
  localparam int ICR_TB  = 1;
  localparam int ICR_TOD = 2;
  localparam int ICR_SP  = 3;
  localparam int ICR_FLG = 4;

endpackage

// File: rtl/cia_negedge.sv
// Falling-edge detector for an asynchronous pad.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   phi2_dn : PHI2 falling-edge strobe; the consumer samples neg on it
//   pin     : asynchronous pad input (idle high)
//   neg     : a falling edge was seen and not yet consumed at phi2_dn
module cia_negedge (
  input  logic clk,
  input  logic rst,
  input  logic phi2_dn,
  input  logic pin,
  output logic neg
);

  logic sync_p0, sync_p1, sync_p2;
  logic pend;

  // Synchroniser plus one history stage; reset to the idle-high level so
  // leaving reset never fabricates an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge is held until the next phi2_dn consumes it; a level held low
  // produces no further edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= (sync_p2 & ~sync_p1) | (pend & ~phi2_dn);
    end
  end

  assign neg = pend;

endmodule

// File: rtl/cia_icr.sv
// CIA interrupt control register (register $D).
//   clk, res_n       : system clock, asynchronous active-low reset
//   phi2_up, phi2_dn : PHI2 edge strobes; state changes only on phi2_dn
//   rd, we, addr     : bus read cycle, write strobe, register address
//   data             : write data (bit 7 = set/clear, bits 4:0 = mask bits)
//   ta_int..sp_int   : one-PHI2-cycle event pulses from timers, TOD, serial
//   flag             : asynchronous FLAG pad, falling edge active
//   icr_rd           : {ir, 2'b00, flags[4:0]}
//   irq_n            : interrupt request, active low
module cia_icr
  import cia::*;
#(
  parameter int IRQ_DELAY = 1,
  parameter bit TB_BUG    = 1'b1
) (
  input  logic  clk,
  input  logic  res_n,
  input  logic  phi2_up,
  input  logic  phi2_dn,
  input  logic  rd,
  input  logic  we,
  input  reg4_t addr,
  input  reg8_t data,
  input  logic  ta_int,
  input  logic  tb_int,
  input  logic  tod_int,
  input  logic  sp_int,
  input  logic  flag,
  output reg8_t icr_rd,
  output logic  irq_n
);

  logic [4:0] flags, mask;
  logic       ir;
  logic       ir_req_p1;

  logic       rst_int;
  logic       flg_neg;
  logic       sel, wr, clr;
  logic [4:0] src, flags_nxt, mask_nxt;
  logic       req_nxt, ir_nxt;
  icr_t       icr_v;
  logic       unused_ok;

  assign unused_ok = &{1'b0, phi2_up, data[6:5]};

  assign rst_int = ~res_n;

  cia_negedge u_flag_edge (
    .clk     (clk),
    .rst     (rst_int),
    .phi2_dn (phi2_dn),
    .pin     (flag),
    .neg     (flg_neg)
  );

  assign sel = (addr == ICR_ADDR);
  assign wr  = we && sel;
  // A write wins over a simultaneous read, so the read-clear is suppressed.
  assign clr = rd && sel && !wr;

  always_comb begin
    src           = '0;
    src[ICR_TA]   = ta_int;
    // The 6526 loses a timer B underflow that lands in the ICR read cycle.
    src[ICR_TB]   = tb_int & ~(TB_BUG & clr);
    src[ICR_TOD]  = tod_int;
    src[ICR_SP]   = sp_int;
    src[ICR_FLG]  = flg_neg;

    // New events are applied after the read-clear so they survive it.
    flags_nxt = (clr ? 5'b0 : flags) | src;

    mask_nxt = mask;
    if (wr) begin
      if (data[7]) mask_nxt = mask | data[4:0];
      else         mask_nxt = mask & ~data[4:0];
    end

    req_nxt = |(flags_nxt & mask_nxt);

    // ir is sticky: only a read (or reset) drops it, never a mask clear.
    if (IRQ_DELAY == 0) ir_nxt = (clr ? 1'b0 : ir) | req_nxt;
    else                ir_nxt = clr ? 1'b0 : (ir | ir_req_p1);
  end

  // phi2_dn stage boundary: flags, mask, request pipeline, ir
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      flags     <= '0;
      mask      <= '0;
      ir        <= 1'b0;
      ir_req_p1 <= 1'b0;
    end else if (phi2_dn) begin
      flags     <= flags_nxt;
      mask      <= mask_nxt;
      ir        <= ir_nxt;
      ir_req_p1 <= (IRQ_DELAY != 0) ? req_nxt : 1'b0;
    end
  end

  always_comb begin
    icr_v        = '0;
    icr_v.ir     = ir;
    icr_v.flg    = flags[ICR_FLG];
    icr_v.sp     = flags[ICR_SP];
    icr_v.tod    = flags[ICR_TOD];
    icr_v.tb     = flags[ICR_TB];
    icr_v.ta     = flags[ICR_TA];
  end

  assign icr_rd = icr_v;
  assign irq_n  = ~ir;

endmodule

// File: tb/tb_cia_icr.sv
module tb_cia_icr;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       phi2_up = 1'b0, phi2_dn = 1'b0;
  logic       rd = 1'b0, we = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] data = 8'h00;
  logic       ta_int = 1'b0, tb_int = 1'b0, tod_int = 1'b0, sp_int = 1'b0;
  logic       flag = 1'b1;

  logic [7:0] d_icr [2];
  logic       d_irq [2];

  // Instance 0: 6526 timing with the timer B bug; instance 1: 6526A, no bug.
  cia_icr #(.IRQ_DELAY(1), .TB_BUG(1'b1)) dut_a (
    .clk(clk), .res_n(res_n), .phi2_up(phi2_up), .phi2_dn(phi2_dn),
    .rd(rd), .we(we), .addr(addr), .data(data),
    .ta_int(ta_int), .tb_int(tb_int), .tod_int(tod_int), .sp_int(sp_int),
    .flag(flag), .icr_rd(d_icr[0]), .irq_n(d_irq[0]));

  cia_icr #(.IRQ_DELAY(0), .TB_BUG(1'b0)) dut_b (
    .clk(clk), .res_n(res_n), .phi2_up(phi2_up), .phi2_dn(phi2_dn),
    .rd(rd), .we(we), .addr(addr), .data(data),
    .ta_int(ta_int), .tb_int(tb_int), .tod_int(tod_int), .sp_int(sp_int),
    .flag(flag), .icr_rd(d_icr[1]), .irq_n(d_irq[1]));

  initial forever #5 clk = ~clk;

  // PHI2 is 8 clk long: up strobe in slot 0, down strobe in slot 4.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % 8;
      phi2_up = (cnt == 0);
      phi2_dn = (cnt == 4);
    end
  end

  // ---------------- reference model ----------------
  logic [4:0] mflags [2];
  logic [4:0] mmask  [2];
  logic       mir    [2];
  bit         q0[$];
  bit         q1[$];
  logic       mflag_prev;

  function automatic int dly_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit bug_of(int i);
    return (i == 0);
  endfunction

  function automatic logic [7:0] mexp(int i);
    return {mir[i], 2'b00, mflags[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mflags[i] = '0;
      mmask[i]  = '0;
      mir[i]    = 1'b0;
    end
    q0.delete();
    q1.delete();
    mflag_prev = 1'b1;
  endtask

  // One PHI2 falling edge: events land after any read-clear, then the
  // request travels through a FIFO of length IRQ_DELAY before raising ir.
  task automatic model_step();
    logic fe, sel, wr, clr, req;
    logic [4:0] ev;
    fe  = mflag_prev & ~flag;
    mflag_prev = flag;
    sel = (addr == 4'hD);
    wr  = we && sel;
    clr = rd && sel && !wr;
    for (int i = 0; i < 2; i++) begin
      ev = {fe, sp_int, tod_int, tb_int & ~(bug_of(i) & clr), ta_int};
      if (clr) begin
        mflags[i] = '0;
        mir[i]    = 1'b0;
        if (i == 0) q0.delete(); else q1.delete();
      end
      mflags[i] = mflags[i] | ev;
      if (wr) mmask[i] = data[7] ? (mmask[i] | data[4:0]) : (mmask[i] & ~data[4:0]);
      req = |(mflags[i] & mmask[i]);
      if (i == 0) begin
        q0.push_back(req);
        if (q0.size() > dly_of(0)) if (q0.pop_front()) mir[0] = 1'b1;
      end else begin
        q1.push_back(req);
        if (q1.size() > dly_of(1)) if (q1.pop_front()) mir[1] = 1'b1;
      end
    end
  endtask

  // ---------------- compare process ----------------
  int         n_chk = 0;
  int         n_fail = 0;
  logic       lit_on = 1'b0;
  string      lit_name = "";
  logic [7:0] lit_icr [2];
  logic       lit_irq [2];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (d_icr[i] !== mexp(i)) begin
          n_fail++;
          $display("FAIL model_icr inst%0d t=%0t got %02h want %02h", i, $time, d_icr[i], mexp(i));
        end
        n_chk++;
        if (d_irq[i] !== ~mir[i]) begin
          n_fail++;
          $display("FAIL model_irq inst%0d t=%0t got %b want %b", i, $time, d_irq[i], ~mir[i]);
        end
        if (lit_on) begin
          n_chk++;
          if (d_icr[i] !== lit_icr[i] || d_irq[i] !== lit_irq[i]) begin
            n_fail++;
            $display("FAIL %s inst%0d dut icr=%02h irq_n=%b want icr=%02h irq_n=%b",
                     lit_name, i, d_icr[i], d_irq[i], lit_icr[i], lit_irq[i]);
          end
          n_chk++;
          if (mexp(i) !== lit_icr[i] || mir[i] !== ~lit_irq[i]) begin
            n_fail++;
            $display("FAIL %s_model inst%0d model icr=%02h ir=%b want icr=%02h irq_n=%b",
                     lit_name, i, mexp(i), mir[i], lit_icr[i], lit_irq[i]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    do @(posedge clk); while (!phi2_dn);
    if (res_n) model_step();
    #2;
  endtask

  task automatic idle();
    rd = 0; we = 0; addr = 4'h0; data = 8'h00;
    ta_int = 0; tb_int = 0; tod_int = 0; sp_int = 0;
  endtask

  task automatic wr_icr(input logic [7:0] v);
    we = 1; addr = 4'hD; data = v;
    step();
    idle();
  endtask

  task automatic rd_icr();
    rd = 1; addr = 4'hD;
    step();
    idle();
  endtask

  task automatic expect_lit(input string nm, input logic [7:0] ia, input logic qa,
                            input logic [7:0] ib, input logic qb);
    lit_name   = nm;
    lit_icr[0] = ia; lit_irq[0] = qa;
    lit_icr[1] = ib; lit_irq[1] = qb;
    lit_on = 1'b1;
    @(negedge clk);
    #1 lit_on = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    idle();
    expect_lit("reset", 8'h00, 1'b1, 8'h00, 1'b1);
    step(); step();
    res_n = 1'b1;

    wr_icr(8'h81);
    ta_int = 1; step(); idle();
    expect_lit("ta_flag", 8'h01, 1'b1, 8'h81, 1'b0);
    step();
    expect_lit("ta_irq", 8'h81, 1'b0, 8'h81, 1'b0);

    wr_icr(8'h82);
    tb_int = 1; step(); idle();
    step();
    expect_lit("ta_tb", 8'h83, 1'b0, 8'h83, 1'b0);
    rd = 1; addr = 4'hD;
    expect_lit("rd_val", 8'h83, 1'b0, 8'h83, 1'b0);
    step(); idle();
    expect_lit("rd_clr", 8'h00, 1'b1, 8'h00, 1'b1);

    wr_icr(8'h1F);
    tod_int = 1; step(); idle();
    expect_lit("tod_masked", 8'h04, 1'b1, 8'h04, 1'b1);
    wr_icr(8'h84);
    expect_lit("mask_en", 8'h04, 1'b1, 8'h84, 1'b0);
    step();
    expect_lit("mask_en_dly", 8'h84, 1'b0, 8'h84, 1'b0);
    rd_icr();

    ta_int = 1; step(); idle();
    rd = 1; addr = 4'hD; sp_int = 1;
    expect_lit("sp_rd_old", 8'h01, 1'b1, 8'h01, 1'b1);
    step(); idle();
    expect_lit("sp_survive", 8'h08, 1'b1, 8'h08, 1'b1);
    rd_icr();

    rd = 1; addr = 4'hD; tb_int = 1;
    step(); idle();
    expect_lit("tb_rd", 8'h00, 1'b1, 8'h02, 1'b1);
    rd_icr();

    flag = 1'b0;
    step();
    expect_lit("flag_set", 8'h10, 1'b1, 8'h10, 1'b1);
    for (int k = 0; k < 4; k++) step();
    expect_lit("flag_once", 8'h10, 1'b1, 8'h10, 1'b1);
    rd_icr();
    for (int k = 0; k < 5; k++) step();
    expect_lit("flag_low_held", 8'h00, 1'b1, 8'h00, 1'b1);
    flag = 1'b1;
    step();

    wr_icr(8'h82);
    tb_int = 1; step(); idle();
    expect_lit("tb_nodly", 8'h02, 1'b1, 8'h82, 1'b0);
    wr_icr(8'h02);
    expect_lit("mask_clr_hold", 8'h82, 1'b0, 8'h82, 1'b0);
    step();
    expect_lit("mask_clr_hold2", 8'h82, 1'b0, 8'h82, 1'b0);
    rd_icr();
    expect_lit("rd_release", 8'h00, 1'b1, 8'h00, 1'b1);

    wr_icr(8'h81);
    ta_int = 1; step(); idle();
    step();
    expect_lit("pre_reset", 8'h81, 1'b0, 8'h81, 1'b0);
    @(posedge clk);
    #3 res_n = 1'b0;
    model_reset();
    expect_lit("mid_reset", 8'h00, 1'b1, 8'h00, 1'b1);
    step();
    res_n = 1'b1;

    for (int n = 0; n < 800; n++) begin
      ta_int  = ($urandom % 6) == 0;
      tb_int  = ($urandom % 6) == 0;
      tod_int = ($urandom % 8) == 0;
      sp_int  = ($urandom % 8) == 0;
      rd      = ($urandom % 5) == 0;
      we      = ($urandom % 6) == 0;
      addr    = (($urandom % 3) != 0) ? 4'hD : 4'($urandom);
      data    = 8'($urandom);
      if (($urandom % 7) == 0) flag = ~flag;
      step();
    end
    idle();
    step();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
